zion_uop_dispatch: RTL and testbench

//  Consumer end of the decoded-uop interface: takes ZionUnit-tagged uops from the decoder,

---
 rtl/zion_uop_dispatch.sv | 149 ++++++++++++++
 tb/tb_zion_uop_dispatch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zion_uop_dispatch.sv
// zion_uop_dispatch
//   Consumer end of the decoded-uop interface. Buffers ZionUnit-tagged uops in
//   order and routes the head uop to the integer, memory or mul/div issue port.
//   NonUnit0 uops retire as no-ops. Unit codes 4..7 are dropped and flagged as
//   illegal. MulDiv issue is throttled by a credit counter that md_done_i
//   replenishes.
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   flush_i            synchronous flush of every buffered uop
//   in_valid/in_ready  decoder handshake; in_unit is the tag, in_uop the payload
//   out_uop            head payload, shared by all unit ports
//   int_*/mem_*/md_*   per-unit valid/ready issue handshakes
//   md_done_i          one MulDiv uop completed (returns one credit)
//   nop_o, ill_o       1-cycle pulses: NonUnit0 head retired / illegal head dropped
module zion_uop_dispatch #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned MD_CREDITS = 2,
  parameter int unsigned UOP_W      = 92
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_unit,
  input  logic [UOP_W-1:0] in_uop,
  output logic [UOP_W-1:0] out_uop,
  output logic             int_valid,
  input  logic             int_ready,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic             md_valid,
  input  logic             md_ready,
  input  logic             md_done_i,
  output logic             nop_o,
  output logic             ill_o
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CRW = 4;

  typedef enum logic [2:0] {
    UNIT_NON = 3'd0,
    UNIT_INT = 3'd1,
    UNIT_MEM = 3'd2,
    UNIT_MD  = 3'd3
  } unit_e;

  logic [UOP_W-1:0] uop_q  [DEPTH];
  logic [2:0]       unit_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [CRW-1:0]   credits_q, credits_d;

  logic [2:0] head_unit;
  logic       head_ok;
  logic       push;
  logic       pop;
  logic       md_pop;

  always_comb begin
    head_unit = unit_q[rd_ptr_q];
    out_uop   = uop_q[rd_ptr_q];
    head_ok   = (count_q != '0) && !flush_i;

    // rst gates in_ready directly so the decoder never sees a stale accept
    // while the asynchronous reset is held.
    in_ready  = !rst && (count_q < CW'(DEPTH)) && !flush_i;
    push      = in_valid && in_ready;

    int_valid = 1'b0;
    mem_valid = 1'b0;
    md_valid  = 1'b0;
    nop_o     = 1'b0;
    ill_o     = 1'b0;
    pop       = 1'b0;
    md_pop    = 1'b0;

    case (head_unit)
      UNIT_INT: begin
        int_valid = head_ok;
        pop       = head_ok && int_ready;
      end
      UNIT_MEM: begin
        mem_valid = head_ok;
        pop       = head_ok && mem_ready;
      end
      UNIT_MD: begin
        md_valid  = head_ok && (credits_q != '0);
        md_pop    = md_valid && md_ready;
        pop       = md_pop;
      end
      UNIT_NON: begin
        nop_o     = head_ok;
        pop       = head_ok;
      end
      default: begin
        ill_o     = head_ok;
        pop       = head_ok;
      end
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end

    // Credits are independent of flush: in-flight MulDiv ops still return them.
    credits_d = credits_q;
    if (md_pop && !md_done_i)
      credits_d = credits_q - CRW'(1);
    else if (!md_pop && md_done_i && (credits_q < CRW'(MD_CREDITS)))
      credits_d = credits_q + CRW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      credits_q <= CRW'(MD_CREDITS);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        uop_q[i]  <= '0;
        unit_q[i] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      credits_q <= credits_d;
      if (push) begin
        uop_q[wr_ptr_q]  <= in_uop;
        unit_q[wr_ptr_q] <= in_unit;
      end
    end
  end

endmodule

// File: tb/tb_zion_uop_dispatch.sv
// tb_zion_uop_dispatch
//   Directed bench for zion_uop_dispatch (DEPTH=2, MD_CREDITS=2). Inputs change
//   1 time unit after a rising edge; outputs are checked 1 time unit later.
module tb_zion_uop_dispatch;

  localparam int unsigned UOP_W = 92;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_unit;
  logic [UOP_W-1:0] in_uop;
  logic [UOP_W-1:0] out_uop;
  logic             int_valid, int_ready;
  logic             mem_valid, mem_ready;
  logic             md_valid,  md_ready;
  logic             md_done_i;
  logic             nop_o, ill_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zion_uop_dispatch #(.DEPTH(2), .MD_CREDITS(2), .UOP_W(UOP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_unit   (in_unit),
    .in_uop    (in_uop),
    .out_uop   (out_uop),
    .int_valid (int_valid),
    .int_ready (int_ready),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .md_valid  (md_valid),
    .md_ready  (md_ready),
    .md_done_i (md_done_i),
    .nop_o     (nop_o),
    .ill_o     (ill_o)
  );

  function automatic logic [UOP_W-1:0] mkuop(input logic [31:0] pc, input logic [4:0] op);
    return {pc, 32'h0000_00A5, 23'h0, op};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Valid/pulse outputs packed as {int,mem,md,nop,ill}.
  function automatic logic [4:0] vv();
    return {int_valid, mem_valid, md_valid, nop_o, ill_o};
  endfunction

  logic [UOP_W-1:0] a, m1, m2, m3, d1, d2, d3, i1, i2, i3, e1, e2, f1, f2, f3, nu, xu, iu;

  initial begin
    a  = mkuop(32'h100, 5'h03);
    m1 = mkuop(32'h200, 5'h01); m2 = mkuop(32'h204, 5'h02); m3 = mkuop(32'h208, 5'h04);
    d1 = mkuop(32'h300, 5'h0A); d2 = mkuop(32'h304, 5'h0B); d3 = mkuop(32'h308, 5'h0C);
    nu = mkuop(32'h400, 5'h00); xu = mkuop(32'h404, 5'h11); iu = mkuop(32'h408, 5'h12);
    i1 = mkuop(32'h500, 5'h05); i2 = mkuop(32'h504, 5'h06); i3 = mkuop(32'h508, 5'h07);
    e1 = mkuop(32'h600, 5'h08); e2 = mkuop(32'h604, 5'h09);
    f1 = mkuop(32'h700, 5'h0D); f2 = mkuop(32'h704, 5'h0E); f3 = mkuop(32'h708, 5'h0F);

    rst = 1'b1; flush_i = 1'b0; in_valid = 1'b0; in_unit = 3'd0; in_uop = '0;
    int_ready = 1'b0; mem_ready = 1'b0; md_ready = 1'b0; md_done_i = 1'b0;

    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valids", vv(), 0);
    chk("rst_out_uop", out_uop, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // 1: single Int uop, 1-cycle latency, no bypass
    in_valid = 1'b1; in_unit = 3'd1; in_uop = a; int_ready = 1'b1;
    #1;
    chk("t1_no_bypass", vv(), 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_int_valid", vv(), 5'b10000);
    chk("t1_out_uop", out_uop, a);
    tick();
    #1;
    chk("t1_empty_after_pop", vv(), 0);
    chk("t1_in_ready", in_ready, 1);
    int_ready = 1'b0;

    // 2: three Mem uops against a 2-deep buffer
    in_valid = 1'b1; in_unit = 3'd2; in_uop = m1;
    tick();
    in_uop = m2;
    #1;
    chk("t2_in_ready_cnt1", in_ready, 1);
    chk("t2_head_m1", out_uop, m1);
    chk("t2_mem_valid", vv(), 5'b01000);
    tick();
    in_uop = m3;
    #1;
    chk("t2_full_in_ready", in_ready, 0);
    tick();
    #1;
    chk("t2_still_full", in_ready, 0);
    chk("t2_hold_m1", out_uop, m1);
    mem_ready = 1'b1;
    #1;
    chk("t2_full_pop_no_push", in_ready, 0);
    chk("t2_issue1", out_uop, m1);
    tick();
    #1;
    chk("t2_issue2", out_uop, m2);
    chk("t2_ready_after_pop", in_ready, 1);
    chk("t2_issue2_valid", vv(), 5'b01000);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t2_issue3", out_uop, m3);
    chk("t2_issue3_valid", vv(), 5'b01000);
    tick();
    #1;
    chk("t2_drained", vv(), 0);
    mem_ready = 1'b0;

    // 3: MulDiv credit exhaustion and return
    md_ready = 1'b1;
    in_valid = 1'b1; in_unit = 3'd3; in_uop = d1;
    tick();
    in_uop = d2;
    #1;
    chk("t3_d1_valid", vv(), 5'b00100);
    chk("t3_d1_uop", out_uop, d1);
    tick();
    in_uop = d3;
    #1;
    chk("t3_d2_valid", vv(), 5'b00100);
    chk("t3_d2_uop", out_uop, d2);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t3_d3_stall", vv(), 0);
    chk("t3_d3_head", out_uop, d3);
    tick();
    #1;
    chk("t3_d3_still_stall", vv(), 0);
    md_done_i = 1'b1;
    #1;
    chk("t3_done_same_cycle", vv(), 0);
    tick();
    md_done_i = 1'b0;
    #1;
    chk("t3_d3_issue", vv(), 5'b00100);
    chk("t3_d3_uop", out_uop, d3);
    tick();
    #1;
    chk("t3_drained", vv(), 0);
    md_ready = 1'b0;

    // 4: NonUnit0, illegal code 5, Int in order
    int_ready = 1'b1;
    in_valid = 1'b1; in_unit = 3'd0; in_uop = nu;
    tick();
    in_unit = 3'd5; in_uop = xu;
    #1;
    chk("t4_nop", vv(), 5'b00010);
    tick();
    in_unit = 3'd1; in_uop = iu;
    #1;
    chk("t4_ill", vv(), 5'b00001);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t4_int", vv(), 5'b10000);
    chk("t4_int_uop", out_uop, iu);
    tick();
    #1;
    chk("t4_drained", vv(), 0);
    int_ready = 1'b0;

    // 5: flush a full buffer
    in_valid = 1'b1; in_unit = 3'd1; in_uop = i1;
    tick();
    in_uop = i2;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t5_full", in_ready, 0);
    chk("t5_head_i1", out_uop, i1);
    flush_i = 1'b1; int_ready = 1'b1; in_valid = 1'b1; in_uop = i3;
    #1;
    chk("t5_flush_valids", vv(), 0);
    chk("t5_flush_in_ready", in_ready, 0);
    tick();
    flush_i = 1'b0; in_valid = 1'b0;
    #1;
    chk("t5_after_flush_ready", in_ready, 1);
    chk("t5_after_flush_empty", vv(), 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t5_reuse_valid", vv(), 5'b10000);
    chk("t5_reuse_uop", out_uop, i3);
    tick();
    int_ready = 1'b0;

    // 6: reset while full with credits at 0
    md_ready = 1'b1;
    in_valid = 1'b1; in_unit = 3'd3; in_uop = e1;
    tick();
    in_uop = e2;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t6_full_stalled", vv(), 0);
    chk("t6_full_ready", in_ready, 0);
    chk("t6_head_e1", out_uop, e1);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_out_uop", out_uop, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_rel_ready", in_ready, 1);
    chk("t6_rel_valids", vv(), 0);
    // Two credits restored: two MD uops issue, the third stalls.
    in_valid = 1'b1; in_uop = f1;
    tick();
    in_uop = f2;
    #1;
    chk("t6_f1_issue", vv(), 5'b00100);
    tick();
    in_uop = f3;
    #1;
    chk("t6_f2_issue", vv(), 5'b00100);
    chk("t6_f2_uop", out_uop, f2);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t6_f3_stall", vv(), 0);
    chk("t6_f3_head", out_uop, f3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
